// File: rtl/alu_slice_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_slice_sequencer_if
//
// Bundles the three buses of the ALU slice sequencer:
//   req_*  upstream request  (valid/ready, operands, function, mode, carry-in)
//   alu_*  4-bit 74181-style slice (operand/function/carry drive, Y/Co/A=B back)
//   rsp_*  downstream response (valid/ready, result, carry-out, equality)
//
// Modports:
//   master  the sequencer: accepts requests, masters the slice, issues responses
//   slave   the environment: request source, the slice itself, response sink
//
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds rsp_zero (result-is-zero flag).
// ---------------------------------------------------------------------------
interface alu_slice_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [3:0]   req_s;
    logic         req_M;
    logic         req_Ci_inverse;

    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_M;
    logic         alu_Ci_inverse;
    logic [3:0]   alu_Y;
    logic         alu_Co_inverse;
    logic         alu_AequalsB;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_y;
    logic         rsp_Co_inverse;
    logic         rsp_AequalsB;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic         rsp_zero;

    modport master (
        input  req_valid, req_a, req_b, req_s, req_M, req_Ci_inverse,
        output req_ready,
        output alu_a, alu_b, alu_s, alu_M, alu_Ci_inverse,
        input  alu_Y, alu_Co_inverse, alu_AequalsB,
        output rsp_valid, rsp_y, rsp_Co_inverse, rsp_AequalsB, rsp_zero,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_a, req_b, req_s, req_M, req_Ci_inverse,
        input  req_ready,
        input  alu_a, alu_b, alu_s, alu_M, alu_Ci_inverse,
        output alu_Y, alu_Co_inverse, alu_AequalsB,
        input  rsp_valid, rsp_y, rsp_Co_inverse, rsp_AequalsB, rsp_zero,
        output rsp_ready
    );
`else
    modport master (
        input  req_valid, req_a, req_b, req_s, req_M, req_Ci_inverse,
        output req_ready,
        output alu_a, alu_b, alu_s, alu_M, alu_Ci_inverse,
        input  alu_Y, alu_Co_inverse, alu_AequalsB,
        output rsp_valid, rsp_y, rsp_Co_inverse, rsp_AequalsB,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_a, req_b, req_s, req_M, req_Ci_inverse,
        input  req_ready,
        input  alu_a, alu_b, alu_s, alu_M, alu_Ci_inverse,
        output alu_Y, alu_Co_inverse, alu_AequalsB,
        input  rsp_valid, rsp_y, rsp_Co_inverse, rsp_AequalsB,
        output rsp_ready
    );
`endif

endinterface

// File: rtl/alu_slice_sequencer.sv
// ---------------------------------------------------------------------------
// alu_slice_sequencer
//
// Runs a 4*NIBBLES-bit ALU operation through one 4-bit 74181-style slice,
// one nibble per cycle, LSB first. The active-low ripple carry is chained
// between passes (arithmetic mode only) and the per-pass A=B flags are ANDed.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (aborts any operation in flight)
//   bus   alu_slice_sequencer_if.master: req_* in, alu_* slice drive/return,
//         rsp_* out
//
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds bus.rsp_zero, high when the
// assembled result is all zeros.
//
// All slice drive and handshake outputs are registered: the next nibble is
// prepared on the edge that consumes the current one, so the slice sees a
// clean operand for the whole cycle and its combinational outputs are
// sampled at the end of that same cycle.
// ---------------------------------------------------------------------------
module alu_slice_sequencer #(
    parameter int NIBBLES = 4
) (
    input logic                   clk,
    input logic                   rst,
    alu_slice_sequencer_if.master bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [W-1:0]     a_q;       // operand A, shifted right one nibble per pass
    logic [W-1:0]     b_q;       // operand B, shifted likewise
    logic [W-1:0]     result;
    logic             carry_n;
    logic             eq;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic             zero_q;
`endif

    logic [W-1:0]     a_next;
    logic [W-1:0]     b_next;
    logic [W+3:0]     result_cat;
    logic [W-1:0]     result_next;
    logic             carry_next;

    // NOTE: every always_comb output gets an unconditional assignment first
    // so that no path leaves a value held, which would infer a latch.
    always_comb begin
        a_next      = a_q >> 4;
        b_next      = b_q >> 4;
        // Shift the new nibble in from the top; after NIBBLES passes the
        // first nibble computed has reached bit 0.
        result_cat  = {bus.alu_Y, result};
        result_next = result_cat[W+3:4];
        // Logic mode has no carry chain: the slice carry input stays
        // inactive and the reported carry-out stays high.
        carry_next  = bus.alu_M ? 1'b1 : bus.alu_Co_inverse;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            idx                <= '0;
            a_q                <= '0;
            b_q                <= '0;
            result             <= '0;
            carry_n            <= 1'b1;
            eq                 <= 1'b0;
            bus.req_ready      <= 1'b1;
            bus.rsp_valid      <= 1'b0;
            bus.alu_a          <= 4'h0;
            bus.alu_b          <= 4'h0;
            bus.alu_s          <= 4'h0;
            bus.alu_M          <= 1'b1;
            bus.alu_Ci_inverse <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q             <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_q                <= bus.req_a;
                        b_q                <= bus.req_b;
                        idx                <= '0;
                        carry_n            <= bus.req_Ci_inverse;
                        eq                 <= 1'b1;
                        result             <= '0;
                        bus.alu_a          <= bus.req_a[3:0];
                        bus.alu_b          <= bus.req_b[3:0];
                        bus.alu_s          <= bus.req_s;
                        bus.alu_M          <= bus.req_M;
                        bus.alu_Ci_inverse <= bus.req_M | bus.req_Ci_inverse;
                        bus.req_ready      <= 1'b0;
                        state              <= RUN;
                    end
                end

                RUN: begin
                    result  <= result_next;
                    eq      <= eq & bus.alu_AequalsB;
                    carry_n <= carry_next;
                    if (idx == LAST_IDX) begin
                        // Last pass: release the slice to quiet drive and
                        // present the response from the next cycle on.
                        bus.alu_a          <= 4'h0;
                        bus.alu_b          <= 4'h0;
                        bus.alu_s          <= 4'h0;
                        bus.alu_M          <= 1'b1;
                        bus.alu_Ci_inverse <= 1'b1;
                        bus.rsp_valid      <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        zero_q             <= (result_next == '0);
`endif
                        state              <= DONE;
                    end else begin
                        idx                <= idx + 1'b1;
                        a_q                <= a_next;
                        b_q                <= b_next;
                        bus.alu_a          <= a_next[3:0];
                        bus.alu_b          <= b_next[3:0];
                        bus.alu_Ci_inverse <= carry_next;
                    end
                end

                DONE: begin
                    // req_ready stays low here, so a request waiting in DONE
                    // is only taken once back in IDLE.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Response fields come straight from registers that only change on
    // acceptance or during RUN, so they are stable for the whole of DONE.
    assign bus.rsp_y          = result;
    assign bus.rsp_Co_inverse = carry_n;
    assign bus.rsp_AequalsB   = eq;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign bus.rsp_zero       = zero_q;
`endif

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_slice_sequencer
//
// Directed bench for alu_slice_sequencer with NIBBLES = 4. A behavioural
// 74181 slice (active-high data) answers the sequencer's alu_* drive
// combinationally. Expected results are hand-computed constants.
// Optional macro ALU_SEQ_ZERO_FLAG_EN enables the rsp_zero comparisons.
// ---------------------------------------------------------------------------
module tb_alu_slice_sequencer;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_slice_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

    alu_slice_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 74181 slice model: arithmetic result is X + Y + carry, logic result is
    // ~(X ^ Y), with X/Y the internal propagate/generate terms selected by S.
    logic [3:0] slice_x;
    logic [3:0] slice_y;
    logic [4:0] slice_sum;
    always_comb begin
        slice_x = bus.alu_a | (bus.alu_b & {4{bus.alu_s[0]}})
                            | (~bus.alu_b & {4{bus.alu_s[1]}});
        slice_y = (bus.alu_a & bus.alu_b & {4{bus.alu_s[3]}})
                | (bus.alu_a & ~bus.alu_b & {4{bus.alu_s[2]}});
        slice_sum = {1'b0, slice_x} + {1'b0, slice_y} + {4'b0000, ~bus.alu_Ci_inverse};
        bus.alu_Y          = bus.alu_M ? ~(slice_x ^ slice_y) : slice_sum[3:0];
        bus.alu_Co_inverse = ~slice_sum[4];
        bus.alu_AequalsB   = (bus.alu_Y == 4'hF);
    end

    int n_vec = 0;
    int n_err = 0;

    // Observations filled by the stimulus tasks.
    int           acc_cyc;
    bit           acc_timeout;
    logic         last_m;
    int           obs_lat;
    bit           obs_timeout;
    bit           obs_ci_ok;
    logic [W-1:0] obs_a_seq;
    logic [W-1:0] obs_y;
    logic         obs_co;
    logic         obs_eq;
    logic         obs_zero;

    // Present a request and wait (bounded) for the edge that accepts it.
    // Afterwards the request fields are scrambled to expose any missing latch.
    task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] s, input logic m, input logic ci);
        bit taken;
        taken = 1'b0;
        bus.req_a = a; bus.req_b = b; bus.req_s = s;
        bus.req_M = m; bus.req_Ci_inverse = ci;
        bus.req_valid = 1'b1;
        last_m = m;
        for (int i = 0; i < 50 && !taken; i++) begin
            taken = bus.req_ready;
            @(posedge clk);
            #1;
        end
        acc_cyc     = cyc;
        acc_timeout = !taken;
        bus.req_valid = 1'b0;
        bus.req_a = ~a; bus.req_b = ~b; bus.req_s = ~s;
        bus.req_M = ~m; bus.req_Ci_inverse = ~ci;
    endtask

    // From the cycle after acceptance: record slice drive while waiting for
    // rsp_valid (bounded), capture the response, then complete the handshake.
    task automatic collect_rsp();
        int k;
        k = 0;
        obs_ci_ok = 1'b1;
        obs_a_seq = '0;
        while (bus.rsp_valid !== 1'b1 && k < 40) begin
            if (k < NIBBLES) begin
                obs_a_seq[4*k +: 4] = bus.alu_a;
                if (last_m && bus.alu_Ci_inverse !== 1'b1) obs_ci_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        obs_lat     = k;
        obs_timeout = (bus.rsp_valid !== 1'b1);
        obs_y       = bus.rsp_y;
        obs_co      = bus.rsp_Co_inverse;
        obs_eq      = bus.rsp_AequalsB;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        obs_zero    = bus.rsp_zero;
`else
        obs_zero    = 1'b0;
`endif
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_s = '0;
        bus.req_M = 1'b0; bus.req_Ci_inverse = 1'b1; bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_Co_inverse, bus.rsp_AequalsB} !== 4'b1010) begin
            n_err++;
            $display("FAIL reset_flags: got rdy/vld/co/eq=%b%b%b%b expected 1010",
                     bus.req_ready, bus.rsp_valid, bus.rsp_Co_inverse, bus.rsp_AequalsB);
        end
        n_vec++;
        if (bus.rsp_y !== 16'h0000) begin
            n_err++; $display("FAIL reset_rsp_y: got %h expected 0000", bus.rsp_y);
        end
        n_vec++;
        if ({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_M, bus.alu_Ci_inverse} !== 14'b00000000000011) begin
            n_err++;
            $display("FAIL reset_quiet: got a=%h b=%h s=%h M=%b Ci=%b expected 0 0 0 1 1",
                     bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_M, bus.alu_Ci_inverse);
        end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        n_vec++;
        if (bus.rsp_zero !== 1'b0) begin
            n_err++; $display("FAIL reset_zero: got %b expected 0", bus.rsp_zero);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_add();
        send_req(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
        collect_rsp();
        n_vec++;
        if (acc_timeout || obs_timeout || obs_lat != NIBBLES) begin
            n_err++;
            $display("FAIL add_latency: got %0d cycles (acc_to=%0b rsp_to=%0b) expected %0d",
                     obs_lat, acc_timeout, obs_timeout, NIBBLES);
        end
        n_vec++;
        if ({obs_y, obs_co, obs_eq} !== {16'h2233, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL add_result: got y=%h co=%b eq=%b expected y=2233 co=1 eq=0",
                     obs_y, obs_co, obs_eq);
        end
        n_vec++;
        if (obs_a_seq !== 16'h1234) begin
            n_err++; $display("FAIL add_nibble_order: got %h expected 1234", obs_a_seq);
        end
        n_vec++;
        if ({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_M, bus.alu_Ci_inverse} !== 14'b00000000000011) begin
            n_err++;
            $display("FAIL add_quiet_after: got a=%h b=%h s=%h M=%b Ci=%b expected 0 0 0 1 1",
                     bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_M, bus.alu_Ci_inverse);
        end
    endtask

    task automatic test_carry_out();
        send_req(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        collect_rsp();
        n_vec++;
        if (obs_timeout || {obs_y, obs_co} !== {16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL carry_out: got y=%h co=%b (to=%0b) expected y=0000 co=0",
                     obs_y, obs_co, obs_timeout);
        end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        n_vec++;
        if (obs_zero !== 1'b1) begin
            n_err++; $display("FAIL carry_out_zero: got %b expected 1", obs_zero);
        end
`endif
    endtask

    task automatic test_carry_in();
        send_req(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0);
        collect_rsp();
        n_vec++;
        if (obs_timeout || {obs_y, obs_co} !== {16'h0003, 1'b1}) begin
            n_err++;
            $display("FAIL carry_in: got y=%h co=%b expected y=0003 co=1", obs_y, obs_co);
        end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        n_vec++;
        if (obs_zero !== 1'b0) begin
            n_err++; $display("FAIL carry_in_zero: got %b expected 0", obs_zero);
        end
`endif
    endtask

    task automatic test_equality();
        send_req(16'hA5A5, 16'hA5A5, 4'b0110, 1'b0, 1'b1);
        collect_rsp();
        n_vec++;
        if (obs_timeout || {obs_y, obs_co, obs_eq} !== {16'hFFFF, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL equal_match: got y=%h co=%b eq=%b expected y=ffff co=1 eq=1",
                     obs_y, obs_co, obs_eq);
        end
        send_req(16'hA5A5, 16'hA5A4, 4'b0110, 1'b0, 1'b1);
        collect_rsp();
        n_vec++;
        if (obs_timeout || {obs_y, obs_co, obs_eq} !== {16'h0000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL equal_differ: got y=%h co=%b eq=%b expected y=0000 co=0 eq=0",
                     obs_y, obs_co, obs_eq);
        end
    endtask

    task automatic test_logic();
        send_req(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0);
        collect_rsp();
        n_vec++;
        if (obs_timeout || {obs_y, obs_co, obs_eq} !== {16'h0FF0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL logic_xor: got y=%h co=%b eq=%b expected y=0ff0 co=1 eq=0",
                     obs_y, obs_co, obs_eq);
        end
        n_vec++;
        if (obs_ci_ok !== 1'b1) begin
            n_err++; $display("FAIL logic_ci_forced: got alu_Ci_inverse low in RUN expected high");
        end
        // XNOR whose top nibble would generate a carry: carry-out must stay 1.
        send_req(16'hF000, 16'hF000, 4'b1001, 1'b1, 1'b1);
        collect_rsp();
        n_vec++;
        if (obs_timeout || {obs_y, obs_co, obs_eq} !== {16'hFFFF, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL logic_xnor: got y=%h co=%b eq=%b expected y=ffff co=1 eq=1",
                     obs_y, obs_co, obs_eq);
        end
    endtask

    task automatic test_backpressure();
        int k;
        send_req(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 40) begin
            @(posedge clk); #1; k++;
        end
        // A second request waits in DONE; it must not be taken early.
        bus.req_a = 16'h1111; bus.req_b = 16'h2222; bus.req_s = 4'b1001;
        bus.req_M = 1'b0; bus.req_Ci_inverse = 1'b1; bus.req_valid = 1'b1;
        last_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_y, bus.rsp_Co_inverse} !== {1'b1, 1'b0, 16'h0100, 1'b1}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b y=%h co=%b expected 1 0 0100 1",
                         i, bus.rsp_valid, bus.req_ready, bus.rsp_y, bus.rsp_Co_inverse);
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_vec++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", bus.rsp_valid, bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a = 16'hDEAD; bus.req_b = 16'hBEEF;
        n_vec++;
        if (bus.req_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_next_accept: got rdy=%b expected 0", bus.req_ready);
        end
        collect_rsp();
        n_vec++;
        if (obs_timeout || obs_lat != NIBBLES || {obs_y, obs_co} !== {16'h3333, 1'b1}) begin
            n_err++;
            $display("FAIL bp_second: got y=%h co=%b lat=%0d expected y=3333 co=1 lat=%0d",
                     obs_y, obs_co, obs_lat, NIBBLES);
        end
    endtask

    task automatic test_back_to_back();
        int first_acc;
        send_req(16'h0102, 16'h0304, 4'b1001, 1'b0, 1'b1);
        first_acc = acc_cyc;
        collect_rsp();
        send_req(16'h7777, 16'h0001, 4'b1001, 1'b0, 1'b1);
        n_vec++;
        if (acc_timeout || acc_cyc - first_acc != NIBBLES + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles expected %0d", acc_cyc - first_acc, NIBBLES + 2);
        end
        collect_rsp();
        n_vec++;
        if (obs_timeout || {obs_y, obs_co} !== {16'h7778, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_result: got y=%h co=%b expected y=7778 co=1", obs_y, obs_co);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen_valid;
        send_req(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
        @(posedge clk); #1;          // now in the second RUN cycle
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL midrst_state: got rdy=%b vld=%b expected 1 0", bus.req_ready, bus.rsp_valid);
        end
        n_vec++;
        if ({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_M, bus.alu_Ci_inverse} !== 14'b00000000000011) begin
            n_err++;
            $display("FAIL midrst_quiet: got a=%h b=%h s=%h M=%b Ci=%b expected 0 0 0 1 1",
                     bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_M, bus.alu_Ci_inverse);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < NIBBLES + 3; i++) begin
            if (bus.rsp_valid !== 1'b0) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen_valid) begin
            n_err++; $display("FAIL midrst_no_rsp: got rsp_valid=1 after abort expected 0");
        end
        send_req(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b1);
        collect_rsp();
        n_vec++;
        if (obs_timeout || {obs_y, obs_co} !== {16'h5432, 1'b1}) begin
            n_err++;
            $display("FAIL midrst_recover: got y=%h co=%b expected y=5432 co=1", obs_y, obs_co);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_out();
        test_carry_in();
        test_equality();
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_slice_sequencer.md
# alu_slice_sequencer

Multi-cycle controller that computes a 4·NIBBLES-bit ALU operation on a single 4-bit 74181-style ALU slice, one nibble per cycle, LSB first. It chains the active-low ripple carry between passes and ANDs the per-slice equality flags. It drives the slice's operand/function/carry inputs and consumes its Y, Co_inverse and AequalsB outputs. Upstream and downstream connect through valid/ready handshakes.

## Interface
- NIBBLES, default 4: number of slice passes; data width W = 4·NIBBLES.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a, req_b  in  W  operands.
- req_s  in  4  slice function select.
- req_M  in  1  1 = logic mode, 0 = arithmetic mode.
- req_Ci_inverse  in  1  active-low carry-in to nibble 0.
- alu_a, alu_b  out  4  current operand nibbles to the slice.
- alu_s  out  4  function select to the slice.
- alu_M  out  1  mode to the slice.
- alu_Ci_inverse  out  1  carry to the slice.
- alu_Y  in  4  slice result. The slice is combinational and is sampled in the same cycle it is driven.
- alu_Co_inverse  in  1  slice active-low carry-out.
- alu_AequalsB  in  1  slice equality flag.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_y  out  W  assembled result.
- rsp_Co_inverse  out  1  final active-low carry-out.
- rsp_AequalsB  out  1  AND of all slice AequalsB outputs.

## Operation
- **States:** IDLE, RUN, DONE. Registers: state, operand/function latch, nibble index idx, carry_n, result, eq.
- **IDLE**
  - req_ready = 1.
  - On req_valid: latch all request fields, idx ← 0, carry_n ← req_Ci_inverse, eq ← 1, result ← 0. Go to RUN.
- **RUN**
  - Drive alu_a = a[4·idx+3:4·idx], alu_b likewise, alu_s = s, alu_M = M.
  - alu_Ci_inverse = carry_n when M = 0; forced to 1 when M = 1.
  - Each edge: result nibble idx ← alu_Y; eq ← eq & alu_AequalsB.
  - carry_n ← alu_Co_inverse when M = 0. When M = 1, carry_n ← 1.
  - When idx = NIBBLES−1: go to DONE. Otherwise idx ← idx+1.
- **DONE**
  - rsp_valid = 1, driven from the registers.
  - On rsp_ready, go to IDLE.
  - req_ready = 0, so there is no overlap between operations.
- **Quiet drive:** outside RUN, alu_a = alu_b = alu_s = 0, alu_M = 1, alu_Ci_inverse = 1.
- **Response stability:** rsp_y, rsp_Co_inverse and rsp_AequalsB hold their values from entry into DONE until the next acceptance. Latched request fields are unaffected by req_* changes after acceptance.
- **Arithmetic:** no width extension. Carry beyond the top nibble appears only in rsp_Co_inverse.

## Timing
- **Reset values** (one edge with rst = 1): state IDLE, req_ready 1, rsp_valid 0, rsp_y 0, rsp_Co_inverse 1, rsp_AequalsB 0, all alu_* at quiet drive.
- **Reset mid-operation** (RUN or DONE): abort, return to IDLE next cycle, no response issued. rst has priority over every handshake.
- **Latency:** request accepted at edge T; rsp_valid is high from cycle T+NIBBLES+1. Minimum spacing between acceptances is NIBBLES+2 cycles.
- **Backpressure:** rsp_valid and the result hold indefinitely while rsp_ready = 0.
- **Simultaneous events:** rsp_ready asserted on the first DONE cycle completes the transfer in that cycle. req_valid in DONE is ignored until IDLE.
- **NIBBLES = 1:** RUN lasts exactly one cycle.

## Configuration
- **ALU_SEQ_ZERO_FLAG_EN defined:** adds output rsp_zero (1 bit).
  - Set to 1 exactly when the assembled result is all zeros.
  - Valid and held under the same rules as rsp_y.
  - Reset value 0.
- **ALU_SEQ_ZERO_FLAG_EN undefined:** the port and its logic do not exist. All other behaviour is identical.

## Test plan
- **Add, no carry:** NIBBLES = 4, s = 1001, M = 0, Ci_inverse = 1, a = 0x1234, b = 0x0FFF → rsp_y = 0x2233, rsp_Co_inverse = 1, rsp_valid at T+5.
- **Add, carry out:** a = 0xFFFF, b = 0x0001, s = 1001, M = 0, Ci_inverse = 1 → rsp_y = 0x0000, rsp_Co_inverse = 0, rsp_zero = 1 when ALU_SEQ_ZERO_FLAG_EN is defined.
- **Equality:** s = 0110, M = 0, Ci_inverse = 1, a = b = 0xA5A5 → rsp_y = 0xFFFF, rsp_AequalsB = 1. Repeat with b = 0xA5A4 → rsp_AequalsB = 0.
- **Logic XOR:** s = 0110, M = 1, a = 0xF0F0, b = 0xFF00 → rsp_y = 0x0FF0, rsp_Co_inverse = 1, alu_Ci_inverse = 1 in every RUN cycle.
- **Backpressure:** hold rsp_ready = 0 for 3 cycles in DONE → rsp_* stable, req_ready = 0, and a concurrent req_valid is not accepted until the cycle after the handshake.
- **Reset mid-operation:** assert rst during the second RUN cycle → next cycle IDLE, req_ready = 1, rsp_valid stays 0, alu_* at quiet drive.
